// File: rtl/dkm_pkg.sv
// Shared definitions for the drink machine and its payout controller.
package dkm_pkg;

    // Payout controller states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EJ_CAN    = 3'd1,
        ST_EJ_NICKEL = 3'd2,
        ST_EJ_DIME   = 3'd3,
        ST_GAP       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    // Default sizing of the payout controller
    localparam int CW_DEF      = 4;
    localparam int TIMEOUT_DEF = 16;
    localparam int GAP_DEF     = 2;

    // Coin values in cents, as used by the vending machine core
    localparam int NICKEL_CENTS = 5;
    localparam int DIME_CENTS   = 10;

endpackage

// File: rtl/dkm_payout_cnt.sv
// Saturating pending-item counter: adds 0..3 and removes 0..1 per cycle.
module dkm_payout_cnt
    import dkm_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          nonzero,
    output logic          sat
);

    // Two extra bits hold count + 3 without wrapping
    localparam int SW = CW + 2;
    localparam logic [SW-1:0] MAX_S = SW'((1 << CW) - 1);

    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] sum;

    function automatic logic [CW-1:0] sat_clip(input logic [SW-1:0] s);
        return (s > MAX_S) ? MAX_S[CW-1:0] : s[CW-1:0];
    endfunction

    // Net increment/decrement, clipped at full scale; a decrement of an empty count is dropped
    always_comb begin
        sum     = {2'b00, count_q} + {{CW{1'b0}}, inc} - {{(SW-1){1'b0}}, dec & nonzero};
        count_d = sat_clip(sum);
        sat     = (sum > MAX_S);
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign nonzero = |count_q;
    assign count   = count_q;

endmodule

// File: rtl/dkm_payout.sv
// Payout controller: queues can/coin requests and ejects them one at a time
// with an eject/done handshake, a per-item timeout and a forced idle gap.
module dkm_payout
    import dkm_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int GAP     = GAP_DEF,
    parameter int CW      = CW_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic DISPENSE,
    input  logic NICKEL_OUT,
    input  logic DIME_OUT,
    input  logic TWO_DIME_OUT,
    input  logic CAN_DONE,
    input  logic NICKEL_DONE,
    input  logic DIME_DONE,
    output logic CAN_EJECT,
    output logic NICKEL_EJECT,
    output logic DIME_EJECT,
    output logic BUSY,
    output logic OVERFLOW,
    output logic FAULT
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          overflow_q, overflow_d;

    logic          can_dec, nkl_dec, dim_dec, done_sel;
    logic [CW-1:0] can_cnt, nkl_cnt, dim_cnt;
    logic          can_nz, nkl_nz, dim_nz;
    logic          can_sat, nkl_sat, dim_sat;
    logic [1:0]    dim_inc;

    assign dim_inc = {TWO_DIME_OUT, 1'b0} + {1'b0, DIME_OUT};

    dkm_payout_cnt #(.CW(CW)) u_can_cnt (
        .clk(CLK), .rst(RST), .inc({1'b0, DISPENSE}), .dec(can_dec),
        .count(can_cnt), .nonzero(can_nz), .sat(can_sat)
    );

    dkm_payout_cnt #(.CW(CW)) u_nkl_cnt (
        .clk(CLK), .rst(RST), .inc({1'b0, NICKEL_OUT}), .dec(nkl_dec),
        .count(nkl_cnt), .nonzero(nkl_nz), .sat(nkl_sat)
    );

    dkm_payout_cnt #(.CW(CW)) u_dim_cnt (
        .clk(CLK), .rst(RST), .inc(dim_inc), .dec(dim_dec),
        .count(dim_cnt), .nonzero(dim_nz), .sat(dim_sat)
    );

    // Next state, handshake acceptance, eject timer and gap counter
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        gap_d      = gap_q;
        can_dec    = (state_q == ST_EJ_CAN)    && CAN_DONE;
        nkl_dec    = (state_q == ST_EJ_NICKEL) && NICKEL_DONE;
        dim_dec    = (state_q == ST_EJ_DIME)   && DIME_DONE;
        done_sel   = can_dec | nkl_dec | dim_dec;
        overflow_d = overflow_q | can_sat | nkl_sat | dim_sat;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if      (can_nz) state_d = ST_EJ_CAN;
                else if (nkl_nz) state_d = ST_EJ_NICKEL;
                else if (dim_nz) state_d = ST_EJ_DIME;
            end
            ST_EJ_CAN, ST_EJ_NICKEL, ST_EJ_DIME: begin
                // A DONE on the last allowed cycle still wins over the timeout
                if (done_sel) begin
                    state_d = ST_GAP;
                    timer_d = '0;
                    gap_d   = '0;
                end else if (timer_q == T_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == G_LAST) state_d = ST_IDLE;
                else                 gap_d   = gap_q + 1'b1;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, timer, gap counter and sticky overflow registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            gap_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            gap_q      <= gap_d;
            overflow_q <= overflow_d;
        end
    end

    // Outputs decode the registered state only, so at most one EJECT is ever high
    assign CAN_EJECT    = (state_q == ST_EJ_CAN);
    assign NICKEL_EJECT = (state_q == ST_EJ_NICKEL);
    assign DIME_EJECT   = (state_q == ST_EJ_DIME);
    assign FAULT        = (state_q == ST_FAULT);
    assign OVERFLOW     = overflow_q;
    assign BUSY         = (state_q != ST_IDLE) || ((can_cnt | nkl_cnt | dim_cnt) != '0);

endmodule

// File: tb/tb_dkm_payout.sv
// Bench for dkm_payout: directed scenarios plus randomized traffic, checked
// every cycle against a timestamp-based behavioural model of the payout rules.
module tb_dkm_payout;

    localparam int TIMEOUT = 16;
    localparam int GAP     = 2;
    localparam int CW      = 4;
    localparam int MAXC    = (1 << CW) - 1;

    localparam int M_IDLE = 0, M_CAN = 1, M_NKL = 2, M_DIM = 3, M_GAP = 4, M_FLT = 5;

    logic CLK = 1'b0, RST = 1'b0;
    logic DISPENSE = 1'b0, NICKEL_OUT = 1'b0, DIME_OUT = 1'b0, TWO_DIME_OUT = 1'b0;
    logic CAN_DONE = 1'b0, NICKEL_DONE = 1'b0, DIME_DONE = 1'b0;
    logic CAN_EJECT, NICKEL_EJECT, DIME_EJECT, BUSY, OVERFLOW, FAULT;

    dkm_payout #(.TIMEOUT(TIMEOUT), .GAP(GAP), .CW(CW)) dut (
        .CLK(CLK), .RST(RST),
        .DISPENSE(DISPENSE), .NICKEL_OUT(NICKEL_OUT), .DIME_OUT(DIME_OUT),
        .TWO_DIME_OUT(TWO_DIME_OUT),
        .CAN_DONE(CAN_DONE), .NICKEL_DONE(NICKEL_DONE), .DIME_DONE(DIME_DONE),
        .CAN_EJECT(CAN_EJECT), .NICKEL_EJECT(NICKEL_EJECT), .DIME_EJECT(DIME_EJECT),
        .BUSY(BUSY), .OVERFLOW(OVERFLOW), .FAULT(FAULT)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0;

    // Reference model: mode, pending counts, sticky overflow, edge timestamps
    int mode = M_IDLE;
    int pend[3] = '{0, 0, 0};
    bit ovf = 1'b0;
    int now = 0, ej_start = 0, gap_end = 0;

    // Observed-ejection monitor
    int rises[3] = '{0, 0, 0};
    int hi[3] = '{0, 0, 0};
    bit prev[3] = '{0, 0, 0};
    int seq_code = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mode = M_IDLE;
        pend = '{0, 0, 0};
        ovf  = 1'b0;
    endtask

    task automatic model_step();
        int inc[3];
        int dec[3];
        bit done;
        int p;
        now++;
        inc[0] = int'(DISPENSE);
        inc[1] = int'(NICKEL_OUT);
        inc[2] = int'(DIME_OUT) + 2 * int'(TWO_DIME_OUT);
        dec = '{0, 0, 0};
        done = (mode == M_CAN && CAN_DONE) || (mode == M_NKL && NICKEL_DONE) ||
               (mode == M_DIM && DIME_DONE);
        if (mode == M_IDLE) begin
            if      (pend[0] > 0) begin mode = M_CAN; ej_start = now; end
            else if (pend[1] > 0) begin mode = M_NKL; ej_start = now; end
            else if (pend[2] > 0) begin mode = M_DIM; ej_start = now; end
        end else if (mode >= M_CAN && mode <= M_DIM) begin
            if (done) begin
                dec[mode - 1] = 1;
                mode = M_GAP;
                gap_end = now + GAP;
            end else if (now == ej_start + TIMEOUT) begin
                mode = M_FLT;
            end
        end else if (mode == M_GAP) begin
            if (now == gap_end) mode = M_IDLE;
        end
        for (int i = 0; i < 3; i++) begin
            p = pend[i] + inc[i] - dec[i];
            if (p > MAXC) begin p = MAXC; ovf = 1'b1; end
            pend[i] = p;
        end
    endtask

    task automatic check_outputs(input string ph);
        chk({ph, ".can_eject"},    int'(CAN_EJECT),    int'(mode == M_CAN));
        chk({ph, ".nickel_eject"}, int'(NICKEL_EJECT), int'(mode == M_NKL));
        chk({ph, ".dime_eject"},   int'(DIME_EJECT),   int'(mode == M_DIM));
        chk({ph, ".busy"},         int'(BUSY),
            int'(mode != M_IDLE || pend[0] + pend[1] + pend[2] > 0));
        chk({ph, ".overflow"},     int'(OVERFLOW),     int'(ovf));
        chk({ph, ".fault"},        int'(FAULT),        int'(mode == M_FLT));
        chk({ph, ".can_cnt"},      int'(dut.can_cnt),  pend[0]);
        chk({ph, ".nkl_cnt"},      int'(dut.nkl_cnt),  pend[1]);
        chk({ph, ".dim_cnt"},      int'(dut.dim_cnt),  pend[2]);
    endtask

    task automatic clr_mon();
        rises = '{0, 0, 0};
        hi = '{0, 0, 0};
        seq_code = 0;
    endtask

    task automatic monitor();
        bit e[3];
        e[0] = CAN_EJECT; e[1] = NICKEL_EJECT; e[2] = DIME_EJECT;
        for (int i = 0; i < 3; i++) begin
            if (e[i] && !prev[i]) begin
                rises[i]++;
                seq_code = seq_code * 10 + i + 1;
            end
            if (e[i]) hi[i]++;
            prev[i] = e[i];
        end
    endtask

    task automatic step(input bit dsp, input bit nk, input bit dm, input bit tdm,
                        input bit cd, input bit nd, input bit dd, input string ph);
        DISPENSE = dsp; NICKEL_OUT = nk; DIME_OUT = dm; TWO_DIME_OUT = tdm;
        CAN_DONE = cd; NICKEL_DONE = nd; DIME_DONE = dd;
        @(posedge CLK);
        model_step();
        #1;
        check_outputs(ph);
        monitor();
    endtask

    // Asserted between edges; outputs must fall before the next clock edge
    task automatic apply_reset(input string ph);
        DISPENSE = 0; NICKEL_OUT = 0; DIME_OUT = 0; TWO_DIME_OUT = 0;
        CAN_DONE = 0; NICKEL_DONE = 0; DIME_DONE = 0;
        RST = 1'b1;
        model_reset();
        #1;
        check_outputs({ph, ".rst"});
        prev = '{0, 0, 0};
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // One cycle of random pulses; DONE answered dly cycles into an ejection (dly<0: never)
    task automatic auto_step(input int pct, input int dly, input bit stray, input string ph);
        bit dn[3];
        bit dsp, nk, dm, tdm;
        dsp = ($urandom_range(99) < pct);
        nk  = ($urandom_range(99) < pct);
        dm  = ($urandom_range(99) < pct);
        tdm = ($urandom_range(99) < pct);
        dn = '{0, 0, 0};
        if (dly >= 0 && mode >= M_CAN && mode <= M_DIM && now - ej_start >= dly)
            dn[mode - 1] = 1'b1;
        if (stray)
            for (int i = 0; i < 3; i++) if ($urandom_range(3) == 0) dn[i] = 1'b1;
        step(dsp, nk, dm, tdm, dn[0], dn[1], dn[2], ph);
    endtask

    task automatic drain(input int dly, input int max_cyc, input string ph);
        int k;
        k = 0;
        while (!(mode == M_IDLE && pend[0] == 0 && pend[1] == 0 && pend[2] == 0) && k < max_cyc) begin
            auto_step(0, dly, 1'b0, ph);
            k++;
        end
        chk({ph, ".drained"}, int'(k < max_cyc), 1);
    endtask

    initial begin
        int k;
        int pct, dly;
        bit stray;

        // Reset state
        apply_reset("init");

        // Can and nickel together, DONE two cycles into each ejection
        clr_mon();
        step(1, 1, 0, 0, 0, 0, 0, "s1");
        k = 0;
        while (!(mode == M_GAP && rises[1] == 1) && k < 60) begin
            auto_step(0, 2, 1'b0, "s1");
            k++;
        end
        chk("s1.reached_gap", int'(k < 60), 1);
        chk("s1.order", seq_code, 12);
        chk("s1.can_high", hi[0], 3);

        // While in GAP: two+one dimes, then a can one cycle later
        clr_mon();
        step(0, 0, 1, 1, 0, 0, 0, "s2");
        step(1, 0, 0, 0, 0, 0, 0, "s2");
        chk("s2.dime_cnt3", int'(dut.dim_cnt), 3);
        drain(2, 200, "s2");
        chk("s2.order", seq_code, 1333);
        chk("s2.busy_end", int'(BUSY), 0);

        // Nickel never answered: timeout into FAULT
        apply_reset("s3");
        clr_mon();
        step(0, 1, 0, 0, 0, 0, 0, "s3");
        k = 0;
        while (mode != M_FLT && k < 40) begin
            step(0, 0, 0, 0, 0, 0, 0, "s3");
            k++;
        end
        chk("s3.nickel_high", hi[1], TIMEOUT);
        chk("s3.fault", int'(FAULT), 1);
        for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0, 0, 0, "s3f");
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 1, 1, "s3f");
        chk("s3.no_more_ejects", rises[0] + rises[1] + rises[2], 1);
        apply_reset("s3");
        chk("s3.fault_cleared", int'(FAULT), 0);

        // DONE on the very last allowed cycle is accepted
        clr_mon();
        step(0, 1, 0, 0, 0, 0, 0, "s3b");
        drain(TIMEOUT - 1, 100, "s3b");
        chk("s3b.no_fault", int'(FAULT), 0);
        chk("s3b.nickel_high", hi[1], TIMEOUT);

        // Sixteen cans with DONE withheld: saturate at 15
        apply_reset("s4");
        clr_mon();
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0, 0, 0, "s4");
        chk("s4.overflow", int'(OVERFLOW), 1);
        chk("s4.can_cnt", int'(dut.can_cnt), MAXC);
        drain(1, 400, "s4");
        chk("s4.can_ejects", rises[0], MAXC);

        // Stray DONEs
        apply_reset("s5");
        clr_mon();
        step(1, 0, 0, 0, 0, 0, 0, "s5");
        step(1, 0, 0, 0, 0, 0, 0, "s5");
        step(0, 0, 0, 0, 0, 1, 1, "s5");
        chk("s5.can_held", int'(CAN_EJECT), 1);
        step(0, 0, 0, 0, 1, 0, 0, "s5");
        step(0, 0, 0, 0, 1, 0, 0, "s5");
        chk("s5.gap_done_ignored", int'(dut.can_cnt), 1);
        drain(1, 100, "s5");
        chk("s5.can_ejects", rises[0], 2);

        // Reset in the middle of a dime ejection
        apply_reset("s6");
        step(0, 0, 0, 1, 0, 0, 0, "s6");
        step(0, 0, 0, 0, 0, 0, 0, "s6");
        chk("s6.dime_eject", int'(DIME_EJECT), 1);
        #1;
        apply_reset("s6");
        clr_mon();
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 0, "s6");
        chk("s6.busy", int'(BUSY), 0);
        chk("s6.no_ejects", rises[0] + rises[1] + rises[2], 0);

        // Randomized traffic
        for (int seg = 0; seg < 30; seg++) begin
            pct   = int'($urandom_range(40));
            dly   = int'($urandom_range(TIMEOUT + 2));
            stray = $urandom_range(1) == 1;
            for (int c = 0; c < 60; c++) begin
                auto_step(pct, dly, stray, "rnd");
                if (mode == M_FLT && $urandom_range(3) == 0) apply_reset("rnd");
            end
            if ($urandom_range(4) == 0) apply_reset("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion before it");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dkm_payout.md
# dkm_payout

Payout controller on the output side of the drink machine. Accepts the machine's one-cycle DISPENSE, NICKEL_OUT, DIME_OUT and TWO_DIME_OUT pulses, queues them as pending can/coin counts, and drives the can and coin ejector mechanisms one item at a time. Each item uses an eject/done handshake with a timeout. Sits between `dkm` and the physical hopper/chute drivers.

## Interface

Parameters:
- TIMEOUT, 16, cycles allowed in an eject state before DONE must arrive
- GAP, 2, idle cycles forced between consecutive ejections (≥1)
- CW, 4, width of each pending counter

Ports:
- CLK  input  1  rising-edge clock (single clock domain)
- RST  input  1  asynchronous, active-high reset
- DISPENSE  input  1  one-cycle pulse; adds 1 pending can
- NICKEL_OUT  input  1  one-cycle pulse; adds 1 pending nickel
- DIME_OUT  input  1  one-cycle pulse; adds 1 pending dime
- TWO_DIME_OUT  input  1  one-cycle pulse; adds 2 pending dimes
- CAN_DONE  input  1  can mechanism completion pulse
- NICKEL_DONE  input  1  nickel hopper completion pulse
- DIME_DONE  input  1  dime hopper completion pulse
- CAN_EJECT  output  1  level; high while a can ejection is requested
- NICKEL_EJECT  output  1  level; high while a nickel ejection is requested
- DIME_EJECT  output  1  level; high while a dime ejection is requested
- BUSY  output  1  state ≠ IDLE or any pending count nonzero
- OVERFLOW  output  1  sticky; a pending counter saturated
- FAULT  output  1  sticky; an ejection timed out

## Operation

- Reset (async, immediate): state IDLE; all counters, timers and outputs 0.
- Pending counters (can, nickel, dime), CW bits, unsigned:
  - Increment per cycle: can +DISPENSE; nickel +NICKEL_OUT; dime +DIME_OUT + 2·TWO_DIME_OUT (max +3).
  - Decrement by 1 when the matching DONE is accepted.
  - Increment and decrement in the same cycle are applied together (net).
  - Result saturates at 2^CW−1. Any clipped increment sets OVERFLOW.
- States:
  - IDLE. Selects the next item with priority can > nickel > dime. Moves to EJ_CAN, EJ_NICKEL or EJ_DIME when that count is nonzero. Stays in IDLE if all counts are zero.
  - EJ_x. x_EJECT = 1, and the timer increments every cycle.
    - x_DONE sampled high: decrement x, clear timer, go to GAP.
    - Timer reaches TIMEOUT without DONE: go to FAULT.
  - GAP. All EJECT = 0 for GAP cycles, then IDLE.
  - FAULT. All EJECT = 0 and FAULT = 1. Counters keep accepting increments; nothing is ejected. Only RST exits.
- DONE pulses are ignored when they do not match the current EJ state, or arrive in IDLE, GAP or FAULT.
- Only one EJECT output is ever high. Outputs are decoded from the registered state.

## Timing

- Pulse sampled at edge N → count nonzero after N → x_EJECT high after edge N+1 if in IDLE. Minimum latency is 1 cycle of queueing.
- x_DONE sampled at edge M → x_EJECT low after M; the count is decremented at M.
- Next EJECT rises no earlier than edge M+GAP+1 (GAP cycles, then 1 IDLE cycle).
- Timeout: EJECT is entered at edge E; if no DONE arrives, FAULT is set at edge E+TIMEOUT.
  - DONE sampled at edge E+TIMEOUT is still accepted; DONE has priority over timeout.
- RST asserted mid-ejection drops EJECT immediately and discards all pending counts.
- BUSY is registered-state based and is valid the cycle after any change.

## Structure

- Shared package `dkm_pkg`: state enum (IDLE, EJ_CAN, EJ_NICKEL, EJ_DIME, GAP, FAULT), default CW and TIMEOUT constants, and the coin-value constants already used by the machine.
- Sub-module `dkm_payout_cnt`: saturating up/down counter, instanced three times.
  - Inputs: inc amount (2 bits), dec.
  - Outputs: count, nonzero, sat.
- The FSM, the timer and the GAP counter stay in the top module.

## Test plan

- Reset, then DISPENSE + NICKEL_OUT in the same cycle; answer each EJECT with DONE 2 cycles later.
  - Expect CAN_EJECT first, NICKEL_EJECT next, separated by GAP+1 low cycles. BUSY = 0 at the end.
- TWO_DIME_OUT + DIME_OUT in one cycle, then DISPENSE 1 cycle later.
  - Expect order can, dime, dime, dime (4 ejections). Dime count reads 3 before the first dime DONE.
- NICKEL_OUT, with NICKEL_DONE never returned.
  - Expect NICKEL_EJECT high for exactly TIMEOUT cycles, then low, and FAULT = 1.
  - Further pulses leave all EJECT outputs 0. RST clears FAULT.
- Send 16 DISPENSE pulses with CW = 4 while CAN_DONE is withheld until the 16th pulse.
  - Expect OVERFLOW = 1 and the can count held at 15. Exactly 15 CAN_EJECT cycles follow.
- Stray DONE handling:
  - DIME_DONE during EJ_CAN: ignored; CAN_EJECT stays high.
  - CAN_DONE during GAP: ignored; count unchanged.
- RST asserted while DIME_EJECT is high with dime count 2: DIME_EJECT falls asynchronously, and after release BUSY = 0 with no further ejections.
